// File: rtl/hazard_ctrl_pkg.sv
// Shared register-file sizing, forwarding-select encodings and FSM states
// for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_SIZE = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_WB      = 2'b01;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } mdState_t;

  // Register 0 is hardwired, so a write to it can never create a dependency.
  function automatic logic regHit(input logic [REG_SIZE-1:0] dst,
                                  input logic                we,
                                  input logic [REG_SIZE-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Mul/div occupancy sequencer: holds EX for MD_LATENCY cycles and pulses
// mdDone on the final one.
module md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = $clog2(MD_LATENCY)
) (
  input  logic clk,
  input  logic rst,
  input  logic mdStartE,
  output logic mdBusy,
  output logic mdDone
);

  // The entry cycle counts as the first occupancy cycle, so the counter
  // covers the remaining MD_LATENCY-1 cycles including the done cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

  mdState_t         state;
  mdState_t         stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mdBusy    = 1'b0;
    mdDone    = 1'b0;
    unique case (state)
      RUN: begin
        if (mdStartE) begin
          mdBusy    = 1'b1;
          stateNext = MD_BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        // mdStartE is ignored here: the instruction still in EX is the one
        // that started this sequence.
        if (cnt != '0) begin
          mdBusy  = 1'b1;
          cntNext = cnt - CNT_W'(1);
        end else begin
          mdDone    = 1'b1;
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use and
// branch stalls, control-flow flushes and mul/div occupancy of EX.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = $clog2(MD_LATENCY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_SIZE-1:0] rsD,
  input  logic [REG_SIZE-1:0] rtD,
  input  logic [REG_SIZE-1:0] rsE,
  input  logic [REG_SIZE-1:0] rtE,
  input  logic [REG_SIZE-1:0] writeRegE,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic [REG_SIZE-1:0] writeRegW,
  input  logic                Regfile_weE,
  input  logic                Regfile_weM,
  input  logic                Regfile_weW,
  input  logic                memToRegE,
  input  logic                memToRegM,
  input  logic                branchD,
  input  logic                jumpD,
  input  logic                branchTakenD,
  input  logic                mdStartE,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                flushD,
  output logic                flushE,
  output logic                bubbleM,
  output logic                forwardAD,
  output logic                forwardBD,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic                mdBusy,
  output logic                mdDone
);

  logic lwStall;
  logic brStall;
  logic depE;
  logic loadDepM;

  md_seq #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_mdSeq (
    .clk      (clk),
    .rst      (rst),
    .mdStartE (mdStartE),
    .mdBusy   (mdBusy),
    .mdDone   (mdDone)
  );

  always_comb begin
    forwardAE = FWD_REGFILE;
    if (regHit(writeRegM, Regfile_weM, rsE))      forwardAE = FWD_MEM;
    else if (regHit(writeRegW, Regfile_weW, rsE)) forwardAE = FWD_WB;

    forwardBE = FWD_REGFILE;
    if (regHit(writeRegM, Regfile_weM, rtE))      forwardBE = FWD_MEM;
    else if (regHit(writeRegW, Regfile_weW, rtE)) forwardBE = FWD_WB;
  end

  assign forwardAD = regHit(writeRegM, Regfile_weM, rsD);
  assign forwardBD = regHit(writeRegM, Regfile_weM, rtD);

  // The branch comparator sits in ID, so it must wait for any EX result and
  // for a load whose data only appears at the end of MEM.
  assign depE     = regHit(writeRegE, Regfile_weE, rsD) | regHit(writeRegE, Regfile_weE, rtD);
  assign loadDepM = memToRegM &
                    (regHit(writeRegM, Regfile_weM, rsD) | regHit(writeRegM, Regfile_weM, rtD));
  assign lwStall  = memToRegE & depE;
  assign brStall  = branchD & (depE | loadDepM);

  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    bubbleM = 1'b0;
    if (mdBusy) begin
      // ID is frozen too, so its own hazards are re-evaluated on release.
      stallF  = 1'b1;
      stallD  = 1'b1;
      stallE  = 1'b1;
      bubbleM = 1'b1;
    end else if (lwStall || brStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else begin
      flushD = jumpD | (branchD & branchTakenD);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-index
// reference model; a second instance exercises the shortest mul/div latency.
module tb_hazard_ctrl;

  localparam int LAT  = 8;
  localparam int LAT2 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0;
  logic [4:0] writeRegE = '0, writeRegM = '0, writeRegW = '0;
  logic       Regfile_weE = 0, Regfile_weM = 0, Regfile_weW = 0;
  logic       memToRegE = 0, memToRegM = 0;
  logic       branchD = 0, jumpD = 0, branchTakenD = 0, mdStartE = 0;

  logic       stallF, stallD, stallE, flushD, flushE, bubbleM;
  logic       forwardAD, forwardBD, mdBusy, mdDone;
  logic [1:0] forwardAE, forwardBE;

  logic       stallF2, stallD2, stallE2, flushD2, flushE2, bubbleM2;
  logic       forwardAD2, forwardBD2, mdBusy2, mdDone2;
  logic [1:0] forwardAE2, forwardBE2;

  int total = 0;
  int bad   = 0;
  int mdPos  = 0;  // index of the current cycle within a mul/div occupancy
  int mdPos2 = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .Regfile_weE(Regfile_weE), .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW),
    .memToRegE(memToRegE), .memToRegM(memToRegM), .branchD(branchD), .jumpD(jumpD),
    .branchTakenD(branchTakenD), .mdStartE(mdStartE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
    .bubbleM(bubbleM), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mdBusy(mdBusy), .mdDone(mdDone)
  );

  hazard_ctrl #(.MD_LATENCY(LAT2)) dut2 (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .Regfile_weE(Regfile_weE), .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW),
    .memToRegE(memToRegE), .memToRegM(memToRegM), .branchD(branchD), .jumpD(jumpD),
    .branchTakenD(branchTakenD), .mdStartE(mdStartE),
    .stallF(stallF2), .stallD(stallD2), .stallE(stallE2), .flushD(flushD2), .flushE(flushE2),
    .bubbleM(bubbleM2), .forwardAD(forwardAD2), .forwardBD(forwardBD2),
    .forwardAE(forwardAE2), .forwardBE(forwardBE2), .mdBusy(mdBusy2), .mdDone(mdDone2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] dst, input logic we, input logic [4:0] src);
    return we && dst != 0 && dst == src;
  endfunction

  function automatic logic [1:0] fwdSel(input logic [4:0] src);
    if (hit(writeRegM, Regfile_weM, src)) return 2'b10;
    if (hit(writeRegW, Regfile_weW, src)) return 2'b01;
    return 2'b00;
  endfunction

  // Caller applies inputs right after a rising edge; checks land mid-cycle.
  task automatic edgeAlign();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle();
    bit busy, done, busy2, done2, lw, br, anyE;
    bit sF, sD, sE, fD, fE, bM;
    #3;
    busy  = (mdPos == 0) ? mdStartE : (mdPos < LAT - 1);
    done  = (mdPos == LAT - 1);
    busy2 = (mdPos2 == 0) ? mdStartE : (mdPos2 < LAT2 - 1);
    done2 = (mdPos2 == LAT2 - 1);
    anyE  = hit(writeRegE, Regfile_weE, rsD) || hit(writeRegE, Regfile_weE, rtD);
    lw    = memToRegE && anyE;
    br    = branchD && (anyE || (memToRegM &&
            (hit(writeRegM, Regfile_weM, rsD) || hit(writeRegM, Regfile_weM, rtD))));
    {sF, sD, sE, fD, fE, bM} = '0;
    if (busy) {sF, sD, sE, bM} = 4'b1111;
    else if (lw || br) {sF, sD, fE} = 3'b111;
    else fD = jumpD || (branchD && branchTakenD);

    chk("forwardAE", forwardAE, fwdSel(rsE));
    chk("forwardBE", forwardBE, fwdSel(rtE));
    chk("forwardAD", forwardAD, hit(writeRegM, Regfile_weM, rsD));
    chk("forwardBD", forwardBD, hit(writeRegM, Regfile_weM, rtD));
    chk("mdBusy", mdBusy, busy);
    chk("mdDone", mdDone, done);
    chk("stallF", stallF, sF);
    chk("stallD", stallD, sD);
    chk("stallE", stallE, sE);
    chk("flushD", flushD, fD);
    chk("flushE", flushE, fE);
    chk("bubbleM", bubbleM, bM);
    chk("mdBusy_lat2", mdBusy2, busy2);
    chk("mdDone_lat2", mdDone2, done2);
    chk("stallE_lat2", stallE2, busy2);

    if (rst) mdPos = 0;
    else if (mdPos == 0) mdPos = mdStartE ? 1 : 0;
    else mdPos = (mdPos == LAT - 1) ? 0 : mdPos + 1;
    if (rst) mdPos2 = 0;
    else if (mdPos2 == 0) mdPos2 = mdStartE ? 1 : 0;
    else mdPos2 = (mdPos2 == LAT2 - 1) ? 0 : mdPos2 + 1;
  endtask

  task automatic clearIn();
    {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
    {Regfile_weE, Regfile_weM, Regfile_weW, memToRegE, memToRegM} = '0;
    {branchD, jumpD, branchTakenD, mdStartE} = '0;
    rst = 0;
  endtask

  initial begin
    // Reset with idle inputs: everything quiet.
    repeat (2) begin edgeAlign(); rst = 1; checkCycle(); end

    // Forwarding priority MEM over WB, then WB alone, then register 0.
    edgeAlign(); clearIn();
    writeRegM = 5; writeRegW = 5; rsE = 5; rtE = 5; Regfile_weM = 1; Regfile_weW = 1; checkCycle();
    edgeAlign(); Regfile_weM = 0; checkCycle();
    edgeAlign(); writeRegM = 0; writeRegW = 0; rsE = 0; rtE = 0; Regfile_weM = 1; checkCycle();

    // Load-use on rt, then drop the load.
    edgeAlign(); clearIn(); memToRegE = 1; Regfile_weE = 1; writeRegE = 7; rtD = 7; checkCycle();
    edgeAlign(); memToRegE = 0; checkCycle();

    // Branch dependent on EX, then a taken branch with no dependency.
    edgeAlign(); clearIn(); branchD = 1; rsD = 3; writeRegE = 3; Regfile_weE = 1; checkCycle();
    edgeAlign(); writeRegE = 4; branchTakenD = 1; checkCycle();
    // Branch waiting on a load in MEM.
    edgeAlign(); clearIn(); branchD = 1; rtD = 9; writeRegM = 9; Regfile_weM = 1; memToRegM = 1; checkCycle();

    // Full mul/div occupancy with overlapping load-use and jump hazards.
    edgeAlign(); clearIn(); mdStartE = 1; checkCycle();
    for (int i = 1; i < LAT + 2; i++) begin
      edgeAlign();
      mdStartE = (i < LAT);
      memToRegE = (i >= 3); Regfile_weE = (i >= 3); writeRegE = 6; rsD = 6; jumpD = (i >= 3);
      checkCycle();
    end

    // Reset while busy with cnt=3, then a fresh sequence.
    edgeAlign(); clearIn(); mdStartE = 1; checkCycle();
    for (int i = 1; i <= 3; i++) begin edgeAlign(); checkCycle(); end
    edgeAlign(); rst = 1; checkCycle();
    edgeAlign(); rst = 0; mdStartE = 0; checkCycle();
    for (int i = 0; i < LAT + 1; i++) begin edgeAlign(); mdStartE = (i < LAT); checkCycle(); end

    // Randomized traffic on a small register pool to provoke matches.
    for (int i = 0; i < 600; i++) begin
      edgeAlign();
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeRegE = 5'($urandom_range(0, 3)); writeRegM = 5'($urandom_range(0, 3));
      writeRegW = 5'($urandom_range(0, 3));
      Regfile_weE = 1'($urandom); Regfile_weM = 1'($urandom); Regfile_weW = 1'($urandom);
      memToRegE = 1'($urandom); memToRegM = 1'($urandom);
      branchD = 1'($urandom); jumpD = ($urandom_range(0, 3) == 0);
      branchTakenD = 1'($urandom);
      mdStartE = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 79) == 0);
      checkCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
